pin_debounce: RTL
=================

PIN_DEBOUNCE -- requirements
Module: pin_debounce

Interface
REQ-001 The block SHALL have parameter N_CH, default 2, giving the number of independent input channels.
REQ-002 The block SHALL have parameter DEB_CYCLES, default 4, giving the consecutive synchronized samples needed to accept a change; legal range is 2..255.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock.
REQ-004 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port ena, input, 1 bit: when high, filter state advances; when low, filter state freezes.
REQ-006 The block SHALL have port din, input, N_CH bits: raw asynchronous pin levels.
REQ-007 The block SHALL have port level_o, output, N_CH bits: debounced level, which feeds downstream user logic directly.
REQ-008 The block SHALL have port rise_o, output, N_CH bits: one-cycle pulse on an accepted 0->1 change.
REQ-009 The block SHALL have port fall_o, output, N_CH bits: one-cycle pulse on an accepted 1->0 change.

Function
REQ-010 Each channel SHALL pass din[i] through a 2-flop synchronizer that runs regardless of ena; its second-stage output is s[i].
REQ-011 Each channel SHALL implement FSM states STABLE and PEND, plus a counter cnt of width $clog2(DEB_CYCLES+1).
REQ-012 In STABLE with s==level, the FSM SHALL remain in STABLE with cnt=0.
REQ-013 In STABLE with s!=level, the FSM SHALL move to PEND with cnt<=1.
REQ-014 In PEND with s==level, the FSM SHALL return to STABLE with cnt<=0 and level unchanged; the glitch is rejected.
REQ-015 In PEND with s!=level and cnt<DEB_CYCLES-1, the FSM SHALL set cnt<=cnt+1.
REQ-016 In PEND with s!=level and cnt==DEB_CYCLES-1, the FSM SHALL set level<=s, cnt<=0, and move to STABLE.
REQ-017 A change SHALL be accepted only after DEB_CYCLES consecutive differing samples of s; level_o SHALL change on the (DEB_CYCLES+2)th rising edge after din settles.
REQ-018 rise_o[i] and fall_o[i] SHALL be registered, SHALL be high only in the cycle in which the new level_o value is first visible, and SHALL never both be high.
REQ-019 Channels SHALL be fully independent; simultaneous changes on several channels SHALL each be filtered and pulsed independently.
REQ-020 With ena low, the FSM, cnt and level SHALL hold their values and rise_o/fall_o SHALL be 0; on re-enable, filtering SHALL resume from the held state.
REQ-021 The counter SHALL never wrap; it SHALL be bounded by REQ-016.

Reset
REQ-022 On rst_n low, asynchronously: synchronizer flops=0, state=STABLE, cnt=0, level_o=0, rise_o=0, fall_o=0.
REQ-023 A reset asserted mid-PEND SHALL discard the pending change; after release, a pin held high SHALL produce rise_o after DEB_CYCLES+2 edges.
REQ-024 Reset release SHALL be treated as synchronous to clk by the integrating top level; no internal reset synchronizer is required.

Configuration
REQ-025 Macro PIN_DEBOUNCE_EDGE_EN SHALL control edge detection: when defined, rise_o/fall_o SHALL behave per REQ-018.
REQ-026 When PIN_DEBOUNCE_EDGE_EN is undefined, rise_o/fall_o SHALL be tied to 0 with no edge flops generated, and level_o behaviour SHALL be unchanged.

Structure
REQ-027 Package pin_debounce_pkg SHALL hold the FSM state enum (STABLE, PEND), the DEB_CYCLES default and its legal-range bounds.
REQ-028 Per-channel logic SHALL be sub-module pin_debounce_ch, instantiated N_CH times by a generate loop in pin_debounce.
REQ-029 An elaboration-time check SHALL fail if DEB_CYCLES<2 or DEB_CYCLES>255.

Verification (DEB_CYCLES=4, N_CH=2)
REQ-030 Clean step: din[0] 0->1 held -> level_o[0]=1 and rise_o[0]=1 for exactly one cycle, both on edge 6; din[1] activity absent.
REQ-031 Glitch: din[0] high for 3 cycles, then low -> level_o[0] stays 0, with no pulses.
REQ-032 Bounce: din[0] toggles every 2 cycles for 20 cycles, then held high -> a single rise_o[0], 6 edges after the final toggle.
REQ-033 ena gating: ena drops after din rises, while cnt=2, for 10 cycles -> no change during the gap; level_o rises 2 edges after ena returns high.
REQ-034 Reset mid-PEND: rst_n pulsed low while cnt=3 -> outputs are 0 immediately; with din still high, rise_o fires 6 edges after release.
REQ-035 Macro off: rerun REQ-030 without PIN_DEBOUNCE_EDGE_EN -> level_o is identical, and rise_o/fall_o stay 0 throughout.

Source files
------------

// File: rtl/pin_debounce_pkg.sv
// Shared definitions for the pin_debounce block: per-channel FSM state,
// the default debounce length and the legal range of that length.
package pin_debounce_pkg;

    // Per-channel filter state.
    typedef enum logic {
        STABLE = 1'b0,
        PEND   = 1'b1
    } deb_state_t;

    // Default number of consecutive differing samples needed to accept a change.
    localparam int DEB_CYCLES_DEF = 4;

    // Legal range of DEB_CYCLES.
    localparam int DEB_CYCLES_MIN = 2;
    localparam int DEB_CYCLES_MAX = 255;

endpackage : pin_debounce_pkg

// File: rtl/pin_debounce_ch.sv
// One debounce channel: a 2-flop synchronizer feeding a STABLE/PEND filter
// that accepts a new level only after DEB_CYCLES consecutive differing samples.
// Edge pulses (rise/fall) exist only when PIN_DEBOUNCE_EDGE_EN is defined;
// otherwise they are tied low and no edge flops are built.
module pin_debounce_ch
    import pin_debounce_pkg::*;
#(
    parameter int DEB_CYCLES = DEB_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic ena,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    localparam int CNT_W = $clog2(DEB_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

    logic             sync1;
    logic             s;
    deb_state_t       state;
    logic [CNT_W-1:0] cnt;

    // Two-flop synchronizer for the asynchronous pin; runs regardless of ena.
    // NOTE: sequential state always uses non-blocking (<=) so every flop samples
    // pre-edge values; a blocking '=' here would collapse the two stages into one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b0;
            s     <= 1'b0;
        end else begin
            sync1 <= din;
            s     <= sync1;
        end
    end

    // Filter FSM: counts consecutive samples that differ from the accepted level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= STABLE;
            cnt   <= '0;
            level <= 1'b0;
        end else if (ena) begin
            case (state)
                STABLE: begin
                    if (s != level) begin
                        state <= PEND;
                        cnt   <= CNT_W'(1);
                    end else begin
                        cnt   <= '0;
                    end
                end
                PEND: begin
                    if (s == level) begin
                        // Glitch shorter than DEB_CYCLES: drop it.
                        state <= STABLE;
                        cnt   <= '0;
                    end else if (cnt == CNT_LAST) begin
                        state <= STABLE;
                        cnt   <= '0;
                        level <= s;
                    end else begin
                        cnt   <= cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state <= STABLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

`ifdef PIN_DEBOUNCE_EDGE_EN
    logic accept;

    // The FSM commits a new level on this edge; the new value is s.
    assign accept = ena && (state == PEND) && (s != level) && (cnt == CNT_LAST);

    // Edge pulses registered on the same edge that updates level, so each pulse
    // coincides with the first cycle the new level is visible.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rise <= 1'b0;
            fall <= 1'b0;
        end else begin
            rise <= accept &&  s;
            fall <= accept && !s;
        end
    end
`else
    assign rise = 1'b0;
    assign fall = 1'b0;
`endif

endmodule : pin_debounce_ch

// File: rtl/pin_debounce.sv
// Multi-channel pin debouncer: N_CH independent pin_debounce_ch instances.
// Optional edge pulses are enabled by defining PIN_DEBOUNCE_EDGE_EN; without it
// rise_o/fall_o are constant 0 and level_o is unaffected.
module pin_debounce
    import pin_debounce_pkg::*;
#(
    parameter int N_CH       = 2,
    parameter int DEB_CYCLES = DEB_CYCLES_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            ena,
    input  logic [N_CH-1:0] din,
    output logic [N_CH-1:0] level_o,
    output logic [N_CH-1:0] rise_o,
    output logic [N_CH-1:0] fall_o
);

    // Reject debounce lengths the counter and FSM are not built for.
    if (DEB_CYCLES < DEB_CYCLES_MIN || DEB_CYCLES > DEB_CYCLES_MAX) begin : g_bad_deb
        $error("pin_debounce: DEB_CYCLES=%0d outside %0d..%0d",
               DEB_CYCLES, DEB_CYCLES_MIN, DEB_CYCLES_MAX);
    end

    // One fully independent filter per channel.
    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        pin_debounce_ch #(
            .DEB_CYCLES (DEB_CYCLES)
        ) u_ch (
            .clk   (clk),
            .rst_n (rst_n),
            .ena   (ena),
            .din   (din[i]),
            .level (level_o[i]),
            .rise  (rise_o[i]),
            .fall  (fall_o[i])
        );
    end

endmodule : pin_debounce
